// File: rtl/dram_pkg.sv
`default_nettype none
// dram_pkg: shared owner/state encodings and constants for the DRAM port arbiter.
// Rev 1.0
package dram_pkg;

  localparam int BURST_LEN   = 32;
  localparam int DRAM_ADDR_W = 25;

  typedef enum logic [1:0] {
    OWN_VGA = 2'd0,
    OWN_CPU = 2'd1,
    OWN_AUX = 2'd2
  } owner_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    MASK  = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// rr_pick2: combinational two-way round-robin picker; a registered flag remembers the last winner.
// Rev 1.0
module rr_pick2 (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic update,
  output logic gnt_a,
  output logic gnt_b
);

  logic last_b_q;
  logic last_b_d;

  always_comb begin
    gnt_b    = req_b && (!last_b_q || !req_a);
    gnt_a    = req_a && !gnt_b;
    last_b_d = last_b_q;
    if (update && (gnt_a || gnt_b)) begin
      last_b_d = gnt_b;
    end
  end

  // Reset value 0 means side A (CPU) was last served, so B wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_b_q <= 1'b0;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
// dram_arbiter: shares one SDRAM controller port among VGA burst, CPU and AUX requesters.
// Rev 1.0
module dram_arbiter
  import dram_pkg::*;
#(
  parameter int ADDR_W  = DRAM_ADDR_W,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_done,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic              aux_we,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_done,
  output logic              err,
  output logic              dram_start,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_write_en,
  output logic              dram_burst_en,
  output logic [DATA_W-1:0] dram_data_in,
  input  logic [DATA_W-1:0] dram_read_data,
  input  logic              dram_data_ready
);

  localparam logic [5:0] TIMEOUT_C = 6'(TIMEOUT);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [5:0]          cnt_q, cnt_d;
  logic                start_q, start_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic                burst_q, burst_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   aux_rdata_q, aux_rdata_d;
  logic                cpu_done_q, cpu_done_d;
  logic                aux_done_q, aux_done_d;
  logic                vga_done_q, vga_done_d;
  logic                err_q, err_d;

  logic                gnt_cpu;
  logic                gnt_aux;
  logic                rr_update;

  // VGA grants must not disturb the CPU/AUX alternation.
  assign rr_update = (state_q == IDLE) && !vga_req;

  rr_pick2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req_a  (cpu_req),
    .req_b  (aux_req),
    .update (rr_update),
    .gnt_a  (gnt_cpu),
    .gnt_b  (gnt_aux)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    start_d     = 1'b0;
    addr_d      = addr_q;
    we_d        = we_q;
    burst_d     = burst_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;
    cpu_done_d  = 1'b0;
    aux_done_d  = 1'b0;
    vga_done_d  = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      // Controller-facing outputs are loaded here so they are stable throughout ISSUE.
      IDLE: begin
        if (vga_req) begin
          owner_d = OWN_VGA;
          state_d = ISSUE;
          start_d = 1'b1;
          addr_d  = vga_addr;
          we_d    = 1'b0;
          burst_d = 1'b1;
          wdata_d = '0;
        end else if (gnt_cpu) begin
          owner_d = OWN_CPU;
          state_d = ISSUE;
          start_d = 1'b1;
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          burst_d = 1'b0;
          wdata_d = cpu_wdata;
        end else if (gnt_aux) begin
          owner_d = OWN_AUX;
          state_d = ISSUE;
          start_d = 1'b1;
          addr_d  = aux_addr;
          we_d    = aux_we;
          burst_d = 1'b0;
          wdata_d = aux_wdata;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = MASK;
      end
      MASK: begin
        cnt_d   = cnt_q + 6'd1;
        state_d = WAIT;
      end
      WAIT: begin
        // Read data is captured while ready is high so rdata is valid alongside done.
        if (dram_data_ready) begin
          state_d = DONE;
          case (owner_q)
            OWN_VGA: vga_done_d = 1'b1;
            OWN_CPU: begin
              cpu_done_d = 1'b1;
              if (!we_q) cpu_rdata_d = dram_read_data;
            end
            OWN_AUX: begin
              aux_done_d = 1'b1;
              if (!we_q) aux_rdata_d = dram_read_data;
            end
            default: ;
          endcase
        end else if (cnt_q == TIMEOUT_C) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      burst_q     <= 1'b0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      aux_done_q  <= 1'b0;
      vga_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      burst_q     <= burst_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
      cpu_done_q  <= cpu_done_d;
      aux_done_q  <= aux_done_d;
      vga_done_q  <= vga_done_d;
      err_q       <= err_d;
    end
  end

  assign dram_start    = start_q;
  assign dram_addr     = addr_q;
  assign dram_write_en = we_q;
  assign dram_burst_en = burst_q;
  assign dram_data_in  = wdata_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign aux_rdata     = aux_rdata_q;
  assign cpu_done      = cpu_done_q;
  assign aux_done      = aux_done_q;
  assign vga_done      = vga_done_q;
  assign err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// tb_dram_arbiter: directed stimulus with an event scoreboard checked by an independent monitor.
module tb_dram_arbiter;

  localparam int AW = 25;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic          vga_done;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_we = 1'b0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_done;
  logic          aux_req = 1'b0;
  logic [AW-1:0] aux_addr = '0;
  logic          aux_we = 1'b0;
  logic [DW-1:0] aux_wdata = '0;
  logic [DW-1:0] aux_rdata;
  logic          aux_done;
  logic          err;
  logic          dram_start;
  logic [AW-1:0] dram_addr;
  logic          dram_write_en;
  logic          dram_burst_en;
  logic [DW-1:0] dram_data_in;
  logic [DW-1:0] dram_read_data = '0;
  logic          dram_data_ready = 1'b1;

  dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(63)) dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_done(vga_done),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_we(aux_we), .aux_wdata(aux_wdata),
    .aux_rdata(aux_rdata), .aux_done(aux_done),
    .err(err), .dram_start(dram_start), .dram_addr(dram_addr),
    .dram_write_en(dram_write_en), .dram_burst_en(dram_burst_en),
    .dram_data_in(dram_data_in), .dram_read_data(dram_read_data),
    .dram_data_ready(dram_data_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_START, EV_VGA_DONE, EV_CPU_DONE, EV_AUX_DONE, EV_ERR} ev_e;
  typedef struct {
    ev_e           kind;
    logic [AW-1:0] addr;
    logic          we;
    logic          burst;
    logic [DW-1:0] data;
    int            cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input ev_e k, input logic [AW-1:0] a, input logic we,
                               input logic b, input logic [DW-1:0] d, input int c);
    ev_t e;
    e.kind = k; e.addr = a; e.we = we; e.burst = b; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  // Monitor: every DUT event consumes the next scoreboard entry.
  task automatic expect_ev(input ev_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected event: got kind %0d expected none (cycle %0d)", int'(k), cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("event kind", 32'(int'(k)), 32'(int'(e.kind)));
    if (e.cyc >= 0) chk("event cycle", 32'(cyc), 32'(e.cyc));
    case (k)
      EV_START: begin
        chk("dram_addr", 32'(dram_addr), 32'(e.addr));
        chk("dram_write_en", 32'(dram_write_en), 32'(e.we));
        chk("dram_burst_en", 32'(dram_burst_en), 32'(e.burst));
        if (e.we) chk("dram_data_in", 32'(dram_data_in), 32'(e.data));
      end
      EV_CPU_DONE: chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
      EV_AUX_DONE: chk("aux_rdata", 32'(aux_rdata), 32'(e.data));
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (dram_start) expect_ev(EV_START);
    if (vga_done)   expect_ev(EV_VGA_DONE);
    if (cpu_done)   expect_ev(EV_CPU_DONE);
    if (aux_done)   expect_ev(EV_AUX_DONE);
    if (err)        expect_ev(EV_ERR);
  end

  // Controller model: ready drops after the arbiter's mask cycle, returns after ctl_wait low WAIT cycles.
  logic [DW-1:0] rd_base  = '0;
  int            ctl_wait = 1;
  bit            ctl_hang = 1'b0;
  logic [AW-1:0] ctl_addr = '0;

  always begin
    @(negedge clk);
    if (dram_start) begin
      ctl_addr = dram_addr;
      @(negedge clk);
      @(posedge clk);
      #1;
      dram_data_ready = 1'b0;
      if (ctl_hang) begin
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (err) break;
        end
      end else begin
        repeat (ctl_wait + 1) @(negedge clk);
      end
      dram_read_data  = rd_base ^ ctl_addr[DW-1:0];
      dram_data_ready = 1'b1;
    end
  end

  // Requester agents: hold req until enough done pulses, drop it the cycle after the last.
  int vga_target = 0, cpu_target = 0, aux_target = 0;
  int vga_dones = 0, cpu_dones = 0, aux_dones = 0;
  bit vs = 1'b0, cs = 1'b0, as_ = 1'b0;

  always begin
    @(negedge clk);
    vs = vga_done; cs = cpu_done; as_ = aux_done;
    @(posedge clk);
    #2;
    if (vs)  vga_dones++;
    if (cs)  cpu_dones++;
    if (as_) aux_dones++;
    vga_req = vga_dones < vga_target;
    cpu_req = cpu_dones < cpu_target;
    aux_req = aux_dones < aux_target;
  end

  task automatic check_zero(input string tag);
    chk({tag, " dram_start"}, 32'(dram_start), 32'd0);
    chk({tag, " dram_addr"}, 32'(dram_addr), 32'd0);
    chk({tag, " dram_write_en"}, 32'(dram_write_en), 32'd0);
    chk({tag, " dram_burst_en"}, 32'(dram_burst_en), 32'd0);
    chk({tag, " dram_data_in"}, 32'(dram_data_in), 32'd0);
    chk({tag, " cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    chk({tag, " aux_rdata"}, 32'(aux_rdata), 32'd0);
    chk({tag, " dones"}, 32'({vga_done, cpu_done, aux_done}), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int c;
  logic [DW-1:0] exp_aux;

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // CPU read, three low WAIT cycles: start one cycle after req, done seven after
    rd_base = 16'hBEEF ^ 16'h0123; ctl_wait = 3;
    cpu_addr = 25'h00123; cpu_we = 1'b0; cpu_wdata = 16'h5555;
    c = cyc;
    push(EV_START, 25'h00123, 1'b0, 1'b0, '0, c + 1);
    push(EV_CPU_DONE, '0, 1'b0, 1'b0, 16'hBEEF, c + 7);
    cpu_target++;
    drain(100);

    // CPU and AUX together for four accesses: AUX, CPU, AUX, CPU
    rd_base = 16'h1000; ctl_wait = 1;
    cpu_addr = 25'h00200; aux_addr = 25'h00300; aux_we = 1'b0;
    push(EV_START, 25'h00300, 1'b0, 1'b0, '0, -1);
    push(EV_AUX_DONE, '0, 1'b0, 1'b0, rd_base ^ 16'h0300, -1);
    push(EV_START, 25'h00200, 1'b0, 1'b0, '0, -1);
    push(EV_CPU_DONE, '0, 1'b0, 1'b0, rd_base ^ 16'h0200, -1);
    push(EV_START, 25'h00300, 1'b0, 1'b0, '0, -1);
    push(EV_AUX_DONE, '0, 1'b0, 1'b0, rd_base ^ 16'h0300, -1);
    push(EV_START, 25'h00200, 1'b0, 1'b0, '0, -1);
    push(EV_CPU_DONE, '0, 1'b0, 1'b0, rd_base ^ 16'h0200, -1);
    exp_aux = rd_base ^ 16'h0300;
    cpu_target += 2; aux_target += 2;
    drain(200);

    // VGA arrives while CPU is in WAIT: CPU finishes, VGA burst next, then CPU again
    rd_base = 16'h2000; ctl_wait = 5;
    cpu_addr = 25'h00400; vga_addr = 25'h80000;
    c = cyc;
    push(EV_START, 25'h00400, 1'b0, 1'b0, '0, c + 1);
    push(EV_CPU_DONE, '0, 1'b0, 1'b0, 16'h2400, c + 9);
    push(EV_START, 25'h80000, 1'b0, 1'b1, '0, c + 11);
    push(EV_VGA_DONE, '0, 1'b0, 1'b0, '0, c + 19);
    push(EV_START, 25'h00400, 1'b0, 1'b0, '0, c + 21);
    push(EV_CPU_DONE, '0, 1'b0, 1'b0, 16'h2400, c + 29);
    cpu_target += 2;
    repeat (4) @(posedge clk); #1;
    vga_target++;
    drain(200);

    // AUX write leaves aux_rdata untouched even though the controller returns data
    rd_base = 16'hDEAD; ctl_wait = 2;
    aux_addr = 25'h00010; aux_we = 1'b1; aux_wdata = 16'h1234;
    push(EV_START, 25'h00010, 1'b1, 1'b0, 16'h1234, -1);
    push(EV_AUX_DONE, '0, 1'b0, 1'b0, exp_aux, -1);
    aux_target++;
    drain(100);

    // Timeout: ready stuck low, err 65 cycles after start, held req retries normally
    rd_base = 16'h3000; ctl_wait = 1; ctl_hang = 1'b1;
    cpu_addr = 25'h00500; cpu_we = 1'b0;
    c = cyc;
    push(EV_START, 25'h00500, 1'b0, 1'b0, '0, c + 1);
    push(EV_ERR, '0, 1'b0, 1'b0, '0, c + 66);
    push(EV_START, 25'h00500, 1'b0, 1'b0, '0, c + 67);
    push(EV_CPU_DONE, '0, 1'b0, 1'b0, 16'h3500, c + 71);
    cpu_target++;
    repeat (10) @(posedge clk); #1;
    ctl_hang = 1'b0;
    drain(200);

    // Reset while AUX is in WAIT: everything clears, no done pulse follows
    rd_base = 16'h4000; ctl_wait = 10;
    aux_addr = 25'h00600; aux_we = 1'b0;
    c = cyc;
    push(EV_START, 25'h00600, 1'b0, 1'b0, '0, c + 1);
    aux_target++;
    repeat (5) @(posedge clk); #1;
    rst = 1'b0;
    aux_target = aux_dones;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset in WAIT");
    repeat (20) @(posedge clk); #1;
    chk("no pending after reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Round-robin pointer is back to CPU after reset: AUX wins the tie
    rd_base = 16'h5000; ctl_wait = 1;
    cpu_addr = 25'h00700; aux_addr = 25'h00701;
    push(EV_START, 25'h00701, 1'b0, 1'b0, '0, -1);
    push(EV_AUX_DONE, '0, 1'b0, 1'b0, 16'h5701, -1);
    push(EV_START, 25'h00700, 1'b0, 1'b0, '0, -1);
    push(EV_CPU_DONE, '0, 1'b0, 1'b0, 16'h5700, -1);
    cpu_target++; aux_target++;
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single SDRAM controller port among three requesters: VGA line fetch (burst read), CPU memory-map unit (single-word read/write) and an auxiliary DMA port (single-word read/write, e.g. UART RX).
- Sits between the requesters and the DRAM controller.
- Sequences each access: issue start strobe, wait for ready, return data and a done pulse.
- Also provides a per-access timeout.

Parameters:
- ADDR_W, 25, DRAM word-address width
- DATA_W, 16, DRAM data width
- TIMEOUT, 63, max cycles in WAIT before abort (counter width 6 bits; must be ≤ 63)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- vga_req  in  1  VGA burst-read request, level
- vga_addr  in  ADDR_W  burst start address, 32-word aligned
- vga_done  out  1  one-cycle pulse: burst complete (data in controller burst buffer)
- cpu_req  in  1  CPU request, level
- cpu_addr  in  ADDR_W  CPU address
- cpu_we  in  1  CPU write enable
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_done
- cpu_done  out  1  one-cycle completion pulse
- aux_req / aux_addr / aux_we / aux_wdata / aux_rdata / aux_done  same as CPU group
- err  out  1  one-cycle pulse: access aborted by timeout
- dram_start  out  1  one-cycle access strobe to controller
- dram_addr  out  ADDR_W  access address
- dram_write_en  out  1  write access
- dram_burst_en  out  1  32-word burst read
- dram_data_in  out  DATA_W  write data
- dram_read_data  in  DATA_W  single-word read data
- dram_data_ready  in  1  controller idle / data valid, level

Behaviour:
- Reset (rst low at posedge):
  - state IDLE; all outputs 0 (rdata buses 0, dram_* 0, done/err 0).
  - rr_last = CPU; timeout counter 0.
  - Reset mid-access abandons the access with no done pulse; requesters must reissue.
- Request rule:
  - Requester holds req with stable addr/we/wdata until its done pulse.
  - Deasserts req the cycle after done, or reasserts to start a new access.
  - A req dropped before done is a protocol error; behaviour undefined.
- Arbitration in IDLE (one decision per cycle, combinational on req lines):
  - VGA has fixed top priority.
  - Otherwise CPU and AUX alternate round-robin: the one not equal to rr_last wins if requesting, else the other.
  - rr_last updates only on a CPU/AUX grant, never on a VGA grant.
- States:
  - IDLE: if any req, latch owner; go to ISSUE next cycle. No req: stay.
  - ISSUE (1 cycle):
    - dram_start=1.
    - dram_addr/we/burst_en/data_in driven from owner: VGA gives burst_en=1, we=0.
    - Clear timeout counter. Go to MASK.
  - MASK (1 cycle): ignore dram_data_ready (controller deasserts ready during this cycle); counter +1; go to WAIT.
  - WAIT:
    - dram_data_ready=1: go to DONE.
    - Counter == TIMEOUT: pulse err, go to IDLE.
    - Else counter +1.
  - DONE (1 cycle):
    - Owner's done=1.
    - Read by CPU/AUX (we=0): capture dram_read_data into that owner's rdata.
    - Write: rdata unchanged.
    - Go to IDLE.
- Registered dram_* outputs hold their values after ISSUE until the next ISSUE, except dram_start, which is a pulse. This avoids glitching the controller.
- Latency from req high in IDLE to done pulse is 4 + W cycles, where W = WAIT cycles before ready (minimum 4).
- A requester reasserting req the cycle after its done is eligible in that IDLE cycle, so back-to-back accesses are separated by one IDLE cycle.
- Simultaneous cpu_req and aux_req with rr_last=CPU: AUX wins. A continuously requesting CPU and AUX therefore strictly alternate.
- Continuous vga_req may starve CPU/AUX; the VGA side must drop req between lines (this is by design).
- The timeout abort on a write still leaves the write indeterminate in DRAM.

Decomposition:
- Shared package dram_pkg:
  - Owner enum (OWN_VGA, OWN_CPU, OWN_AUX).
  - State enum (IDLE, ISSUE, MASK, WAIT, DONE).
  - Constants BURST_LEN=32, DRAM_ADDR_W=25.
- One sub-module: rr_pick2, a combinational 2-way round-robin picker with a registered last-grant flag.
- The remainder is a single FSM.

Test Plan:
- Single CPU read, addr 0x00123, ready returns 3 cycles after MASK, rdata 0xBEEF -> dram_start pulse with addr 0x00123, we=0, burst=0; cpu_done and cpu_rdata=0xBEEF 7 cycles after req.
- cpu_req and aux_req asserted together and held for 4 accesses, rr_last=CPU after reset -> grant order AUX, CPU, AUX, CPU.
- vga_req rises while a CPU access is in WAIT -> CPU completes first; next ISSUE is VGA with burst_en=1, addr 0x80000; CPU waits.
- AUX write 0x1234 to 0x00010 -> dram_write_en=1, dram_data_in=0x1234 at ISSUE; aux_done pulse; aux_rdata unchanged.
- dram_data_ready held low -> err pulses at counter 63; FSM returns to IDLE; no done pulse; next request serviced normally.
- rst low during WAIT -> next cycle all outputs 0, state IDLE, no done pulse.
